// File: rtl/key_conditioner.sv
// Four-key pushbutton conditioner: synchronises each raw key, debounces it and
// produces a clean level plus one-cycle press/release pulses with optional auto-repeat.
module key_conditioner #(
  parameter int DEB_CYCLES  = 500000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int RPT_CYCLES  = 7500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic [3:0] rpt_en,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic       key_any
);

  localparam int MAX_AB  = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > RPT_CYCLES) ? MAX_AB : RPT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // The cycle that moves into PRESS_WAIT/RELEASE_WAIT already counts towards
  // the debounce window, hence the -2 on the terminal count.
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 2);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  logic [3:0] sync_a;
  logic [3:0] sync_b;
  logic [3:0] s;

  // Synchroniser flops reset to the released level so no phantom press follows reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
    end
  end

  assign s = ~sync_b;

  for (genvar i = 0; i < 4; i++) begin : g_key
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] deb_nxt;
    logic [CW-1:0] hr_cnt;
    logic [CW-1:0] hr_nxt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          level_nxt;
    logic          press_nxt;
    logic          release_nxt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state     <= IDLE;
        deb_cnt   <= '0;
        hr_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        deb_cnt   <= deb_nxt;
        hr_cnt    <= hr_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    // hr_cnt is the hold timer in HELD and the repeat-period timer in REPEAT.
    always_comb begin
      state_nxt = state;
      deb_nxt   = deb_cnt;
      hr_nxt    = hr_cnt;
      case (state)
        IDLE: begin
          if (s[i]) begin
            state_nxt = PRESS_WAIT;
            deb_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_nxt = IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state_nxt = HELD;
            hr_nxt    = '0;
          end else begin
            deb_nxt = deb_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!s[i]) begin
            state_nxt = RELEASE_WAIT;
            deb_nxt   = '0;
          end else if (rpt_en[i] && (hr_cnt == HOLD_LAST)) begin
            state_nxt = REPEAT;
            hr_nxt    = '0;
          end else if (hr_cnt != HOLD_LAST) begin
            hr_nxt = hr_cnt + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!s[i]) begin
            state_nxt = RELEASE_WAIT;
            deb_nxt   = '0;
          end else if (!rpt_en[i]) begin
            state_nxt = HELD;
            hr_nxt    = HOLD_LAST;
          end else if (hr_cnt == RPT_LAST) begin
            hr_nxt = '0;
          end else begin
            hr_nxt = hr_cnt + CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (s[i]) begin
            state_nxt = HELD;
            hr_nxt    = '0;
          end else if (deb_cnt == DEB_LAST) begin
            state_nxt = IDLE;
          end else begin
            deb_nxt = deb_cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    always_comb begin
      level_nxt   = (state_nxt == HELD) || (state_nxt == REPEAT) ||
                    (state_nxt == RELEASE_WAIT);
      press_nxt   = ((state == PRESS_WAIT) && (state_nxt == HELD)) ||
                    ((state == HELD) && (state_nxt == REPEAT)) ||
                    ((state == REPEAT) && s[i] && rpt_en[i] && (hr_cnt == RPT_LAST));
      release_nxt = (state == RELEASE_WAIT) && (state_nxt == IDLE);
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

  assign key_any = |key_level;

endmodule
